// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and decode handshake.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        decode_ready;

  modport master (
    output imem_req, imem_addr, instr, pc_out, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, decode_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_out, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, decode_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order imem requests, buffers words for decode.
// Optional FETCH_HALT_EN: stop fetching once an opcode-000000 word is consumed, until the next redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0800_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_queue_if.master           bus,
  output logic [$clog2(DEPTH):0]  outstanding
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [31:0]   s_mem [DEPTH];
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [PW-1:0] q_rd, q_rd_nxt, q_wr, q_wr_nxt;
  logic [PW-1:0] s_rd, s_rd_nxt, s_wr, s_wr_nxt;
  logic [CW-1:0] q_cnt, q_cnt_nxt, out_nxt, drop_cnt, drop_nxt;
  logic          req_nxt, valid_nxt;
  logic [31:0]   instr_nxt, pc_out_nxt;
  logic          grant, pop, push, halted_nxt;
  entry_t        push_entry, head_nxt;
  logic          unused_pc_lsb;

  assign grant         = bus.imem_req & bus.imem_gnt;
  assign pop           = bus.instr_valid & bus.decode_ready;
  // Responses to requests issued before a redirect are discarded until drop_cnt drains.
  assign push          = bus.imem_rvalid & ~bus.redirect & (drop_cnt == '0);
  assign push_entry    = '{instr: bus.imem_rdata, pc: s_mem[s_rd]};
  assign bus.imem_addr = fetch_pc;
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

`ifdef FETCH_HALT_EN
  logic halted;

  always_comb begin
    halted_nxt = halted;
    if (bus.redirect) halted_nxt = 1'b0;
    else if (pop && (bus.instr[31:26] == 6'b000000)) halted_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted <= 1'b0;
    else      halted <= halted_nxt;
  end
`else
  assign halted_nxt = 1'b0;
`endif

  // Next-state for PC, queue, shadow PC FIFO and credit counters; outputs precomputed from it.
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    q_rd_nxt     = q_rd;
    q_wr_nxt     = q_wr;
    s_rd_nxt     = s_rd;
    s_wr_nxt     = s_wr;
    drop_nxt     = drop_cnt;
    out_nxt      = outstanding + CW'(grant) - CW'(bus.imem_rvalid);
    q_cnt_nxt    = q_cnt + CW'(push) - CW'(pop);

    if (grant) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
      s_wr_nxt     = s_wr + PW'(1);
    end
    if (push) begin
      q_wr_nxt = q_wr + PW'(1);
      s_rd_nxt = s_rd + PW'(1);
    end
    if (pop) q_rd_nxt = q_rd + PW'(1);
    if (bus.imem_rvalid && (drop_cnt != '0)) drop_nxt = drop_cnt - CW'(1);

    // Everything still in flight after this cycle becomes stale.
    if (bus.redirect) begin
      fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
      q_rd_nxt     = '0;
      q_wr_nxt     = '0;
      q_cnt_nxt    = '0;
      s_rd_nxt     = '0;
      s_wr_nxt     = '0;
      drop_nxt     = out_nxt;
    end

    head_nxt = q_mem[q_rd_nxt];
    if (push && (q_wr == q_rd_nxt)) head_nxt = push_entry;
    valid_nxt  = (q_cnt_nxt != '0);
    instr_nxt  = valid_nxt ? head_nxt.instr : NOP_INSTR;
    pc_out_nxt = valid_nxt ? head_nxt.pc : 32'h0;
    req_nxt    = (((CW+1)'(q_cnt_nxt) + (CW+1)'(out_nxt)) < (CW+1)'(DEPTH)) && !halted_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= push_entry;
    if (grant && !bus.redirect) s_mem[s_wr] <= fetch_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc        <= RESET_PC;
      q_rd            <= '0;
      q_wr            <= '0;
      q_cnt           <= '0;
      s_rd            <= '0;
      s_wr            <= '0;
      outstanding     <= '0;
      drop_cnt        <= '0;
      bus.imem_req    <= 1'b0;
      bus.instr_valid <= 1'b0;
      bus.instr       <= NOP_INSTR;
      bus.pc_out      <= 32'h0;
    end else begin
      fetch_pc        <= fetch_pc_nxt;
      q_rd            <= q_rd_nxt;
      q_wr            <= q_wr_nxt;
      q_cnt           <= q_cnt_nxt;
      s_rd            <= s_rd_nxt;
      s_wr            <= s_wr_nxt;
      outstanding     <= out_nxt;
      drop_cnt        <= drop_nxt;
      bus.imem_req    <= req_nxt;
      bus.instr_valid <= valid_nxt;
      bus.instr       <= instr_nxt;
      bus.pc_out      <= pc_out_nxt;
    end
  end
endmodule
